snd_cmd_mailbox: RTL

//  Main-CPU -> sound-CPU command mailbox; replaces the single-cycle sound latch/IRQ pulse.
//  - Queues main-CPU command writes in a small FIFO.
//  - Presents one command at a time on a held latch feeding AY port A.
//  - Holds the sound-CPU IRQ level until the Z80 acknowledges it, so no command is lost.

---
 rtl/snd_pkg.sv | 34 +++
 rtl/snd_cmd_mailbox_if.sv | 36 +++
 rtl/snd_cmd_fifo.sv | 63 ++++++
 rtl/snd_cmd_mailbox.sv | 119 +++++++++++
 4 files changed

// File: rtl/snd_pkg.sv
// Shared definitions for the main-CPU -> sound-CPU command mailbox:
// command width, FSM state encoding and status-byte layout.
package snd_pkg;

  localparam int CMD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_HOLD = 2'd2
  } snd_state_e;

  // Status byte: {overflow, fifo_full, fifo_empty, scpu_irq, count[3:0]}
  localparam int STAT_OVF     = 7;
  localparam int STAT_FULL    = 6;
  localparam int STAT_EMPTY   = 5;
  localparam int STAT_IRQ     = 4;
  localparam int STAT_CNT_LSB = 0;
  localparam int STAT_CNT_W   = 4;

  function automatic logic [7:0] stat_pack(input logic ovf, input logic full,
                                           input logic empty, input logic irq,
                                           input logic [STAT_CNT_W-1:0] cnt);
    logic [7:0] s;
    s = '0;
    s[STAT_OVF]   = ovf;
    s[STAT_FULL]  = full;
    s[STAT_EMPTY] = empty;
    s[STAT_IRQ]   = irq;
    s[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
    return s;
  endfunction

endpackage

// File: rtl/snd_cmd_mailbox_if.sv
// Mailbox bus: main-CPU command push, sound-CPU IRQ/ack and status.
// Status signals exist only when SNDCMD_STATUS_EN is defined.
interface snd_cmd_mailbox_if;
  import snd_pkg::*;

  // Handshake: cmd_wr is a strobe whose 0->1 transition pushes cmd_din once;
  // scpu_irq is a level held until a 0->1 transition of irq_ack while pending.
  logic             cmd_wr;
  logic [CMD_W-1:0] cmd_din;
  logic             irq_ack;
  logic [CMD_W-1:0] cmd_dout;
  logic             scpu_irq;
  logic             fifo_full;
  logic             fifo_empty;
  logic             overflow;
  logic [1:0]       state_dbg;
`ifdef SNDCMD_STATUS_EN
  logic             stat_rd;
  logic [7:0]       stat_dout;

  modport master (output cmd_wr, cmd_din, irq_ack, stat_rd,
                  input  cmd_dout, scpu_irq, fifo_full, fifo_empty, overflow,
                         state_dbg, stat_dout);
  modport slave  (input  cmd_wr, cmd_din, irq_ack, stat_rd,
                  output cmd_dout, scpu_irq, fifo_full, fifo_empty, overflow,
                         state_dbg, stat_dout);
`else
  modport master (output cmd_wr, cmd_din, irq_ack,
                  input  cmd_dout, scpu_irq, fifo_full, fifo_empty, overflow,
                         state_dbg);
  modport slave  (input  cmd_wr, cmd_din, irq_ack,
                  output cmd_dout, scpu_irq, fifo_full, fifo_empty, overflow,
                         state_dbg);
`endif

endinterface

// File: rtl/snd_cmd_fifo.sv
// Command FIFO for the sound mailbox: pointers, occupancy count,
// full/empty flags and a sticky overflow flag (set wins over clear).
module snd_cmd_fifo
  import snd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     ovf_clr,
  input  logic [CMD_W-1:0]         din,
  output logic [CMD_W-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt;
  logic             ovf_q;
  logic             do_pop, accept, drop;

  assign full   = (cnt == (AW+1)'(DEPTH));
  assign empty  = (cnt == '0);
  assign do_pop = pop && !empty;
  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign accept = push && (!full || do_pop);
  assign drop   = push && full && !do_pop;

  always_ff @(posedge clk_sys) begin
    if (accept) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({accept, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
      if (drop)         ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  assign dout     = mem[rd_ptr];
  assign count    = cnt;
  assign overflow = ovf_q;

endmodule

// File: rtl/snd_cmd_mailbox.sv
// Main-CPU -> sound-CPU command mailbox: FIFO, held command latch, level IRQ
// with ack holdoff. Define SNDCMD_STATUS_EN for the clear-on-read status byte.
module snd_cmd_mailbox
  import snd_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int HOLDOFF = 64
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  snd_cmd_mailbox_if.slave    bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  snd_state_e       state_q, state_d;
  logic             cmd_wr_q, ack_q;
  logic             push, ack_rise, pop;
  logic             irq_q, irq_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [CMD_W-1:0] dout_q, fifo_dout;
  logic [CW-1:0]    count;
  logic             full, empty, ovf, ovf_clr;

  assign push     = bus.cmd_wr  & ~cmd_wr_q;
  assign ack_rise = bus.irq_ack & ~ack_q;

  snd_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .push     (push),
    .pop      (pop),
    .ovf_clr  (ovf_clr),
    .din      (bus.cmd_din),
    .dout     (fifo_dout),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (ovf)
  );

  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    hold_d  = hold_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          irq_d   = 1'b1;
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        // Only a fresh 0->1 ack counts; a level held into PEND is ignored.
        if (ack_rise) begin
          irq_d = 1'b0;
          if (HOLDOFF == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
            hold_d  = HOLD_LOAD;
          end
        end
      end
      ST_HOLD: begin
        if (hold_q == '0) state_d = ST_IDLE;
        else              hold_d  = hold_q - HW'(1);
      end
      default: begin
        state_d = ST_IDLE;
        irq_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      irq_q    <= 1'b0;
      hold_q   <= '0;
      dout_q   <= '0;
      cmd_wr_q <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      irq_q    <= irq_d;
      hold_q   <= hold_d;
      cmd_wr_q <= bus.cmd_wr;
      ack_q    <= bus.irq_ack;
      if (pop) dout_q <= fifo_dout;
    end
  end

  assign bus.cmd_dout   = dout_q;
  assign bus.scpu_irq   = irq_q;
  assign bus.fifo_full  = full;
  assign bus.fifo_empty = empty;
  assign bus.overflow   = ovf;
  assign bus.state_dbg  = state_q;

`ifdef SNDCMD_STATUS_EN
  logic [7:0] stat_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) stat_q <= stat_pack(1'b0, 1'b0, 1'b1, 1'b0, '0);
    else          stat_q <= stat_pack(ovf, full, empty, irq_q, STAT_CNT_W'(count));
  end

  assign ovf_clr       = bus.stat_rd;
  assign bus.stat_dout = stat_q;
`else
  assign ovf_clr = 1'b0;
`endif

endmodule
